// File: rtl/tank_scheduler.sv
// Per-frame motion/fire scheduler for the two player tanks.
// Each frame (falling edge of i_vga_buzy) it latches both joystick buses, then serves
// both players in round-robin order. The order alternates every frame. Border and
// tank-tank collisions are resolved before a move is committed.
// Optional: define TANK_SCHED_WRAP_EN to make border moves wrap instead of block.
module tank_scheduler #(
    parameter logic [5:0]  GRID_MAX = 6'd39,
    parameter int unsigned MOVE_DIV = 4,
    parameter int unsigned FIRE_CD  = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_run,
    input  logic       i_vga_buzy,
    input  logic [4:0] i_p0_cmd,
    input  logic [4:0] i_p1_cmd,
    output logic [5:0] o_p0_x,
    output logic [5:0] o_p0_y,
    output logic [1:0] o_p0_dir,
    output logic [5:0] o_p1_x,
    output logic [5:0] o_p1_y,
    output logic [1:0] o_p1_dir,
    output logic       o_fire_vld,
    output logic       o_fire_id,
    output logic       o_busy
);

`ifdef TANK_SCHED_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    localparam logic [3:0] MoveLast = 4'(MOVE_DIV - 1);
    localparam logic [5:0] FireCd   = 6'(FIRE_CD);

    typedef enum logic [2:0] {StIdle, StLatch, StSvcA, StSvcB, StDone} state_e;

    state_e          state_q, state_d;
    logic            first_q, first_d;
    logic            vga_prev_q, vga_prev_d;
    logic [1:0][4:0] cmd_q, cmd_d;
    logic [1:0][5:0] x_q, x_d, y_q, y_d;
    logic [1:0][1:0] dir_q, dir_d;
    logic [1:0][3:0] cnt_q, cnt_d;
    logic [1:0][5:0] cd_q, cd_d;
    logic            fire_vld_q, fire_vld_d;
    logic            fire_id_q, fire_id_d;
    logic            busy_q, busy_d;

    logic       tick;
    logic       sel;
    logic [4:0] cmd;
    logic [5:0] cur_x, cur_y, tgt_x, tgt_y, cur_cd, cd_eff;
    logic [3:0] cur_cnt;
    logic [1:0] new_dir;
    logic       edge_hit, attempt, blocked;

    // Frame tick on the falling edge of the VGA busy flag.
    assign tick = vga_prev_q & ~i_vga_buzy;

    // Sequencer and service of the player selected by the current service slot.
    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        vga_prev_d = i_vga_buzy;
        cmd_d      = cmd_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        cd_d       = cd_q;
        fire_vld_d = 1'b0;
        fire_id_d  = fire_id_q;

        sel     = (state_q == StSvcB) ? ~first_q : first_q;
        cmd     = cmd_q[sel];
        cur_x   = x_q[sel];
        cur_y   = y_q[sel];
        cur_cnt = cnt_q[sel];
        cur_cd  = cd_q[sel];

        // Heading priority: up > down > left > right; no bit keeps the heading.
        new_dir = dir_q[sel];
        if (cmd[0]) begin
            new_dir = 2'd0;
        end else if (cmd[1]) begin
            new_dir = 2'd2;
        end else if (cmd[2]) begin
            new_dir = 2'd3;
        end else if (cmd[3]) begin
            new_dir = 2'd1;
        end

        // Target cell; edge_hit marks a step off the grid, tgt then holds the wrapped cell.
        tgt_x    = cur_x;
        tgt_y    = cur_y;
        edge_hit = 1'b0;
        case (new_dir)
            2'd0: begin
                if (cur_y == 6'd0) begin
                    edge_hit = 1'b1;
                    tgt_y    = GRID_MAX;
                end else begin
                    tgt_y = cur_y - 6'd1;
                end
            end
            2'd1: begin
                if (cur_x >= GRID_MAX) begin
                    edge_hit = 1'b1;
                    tgt_x    = 6'd0;
                end else begin
                    tgt_x = cur_x + 6'd1;
                end
            end
            2'd2: begin
                if (cur_y >= GRID_MAX) begin
                    edge_hit = 1'b1;
                    tgt_y    = 6'd0;
                end else begin
                    tgt_y = cur_y + 6'd1;
                end
            end
            default: begin
                if (cur_x == 6'd0) begin
                    edge_hit = 1'b1;
                    tgt_x    = GRID_MAX;
                end else begin
                    tgt_x = cur_x - 6'd1;
                end
            end
        endcase

        attempt = (|cmd[3:0]) && (cur_cnt == MoveLast);
        // The other tank's registered position already reflects an earlier slot this frame.
        blocked = (edge_hit & ~WrapEn) | ((tgt_x == x_q[~sel]) && (tgt_y == y_q[~sel]));
        // Cooldown ages before the fire check, so a shot re-arms FIRE_CD frames later.
        cd_eff  = (cur_cd == 6'd0) ? 6'd0 : cur_cd - 6'd1;

        case (state_q)
            StIdle: begin
                if (tick && i_run) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                cmd_d[0] = i_p0_cmd;
                cmd_d[1] = i_p1_cmd;
                state_d  = StSvcA;
            end
            StSvcA, StSvcB: begin
                dir_d[sel] = new_dir;
                if (attempt) begin
                    cnt_d[sel] = 4'd0;
                    if (!blocked) begin
                        x_d[sel] = tgt_x;
                        y_d[sel] = tgt_y;
                    end
                end else if (cur_cnt != MoveLast) begin
                    cnt_d[sel] = cur_cnt + 4'd1;
                end
                if (cmd[4] && (cd_eff == 6'd0)) begin
                    fire_vld_d = 1'b1;
                    fire_id_d  = sel;
                    cd_d[sel]  = FireCd;
                end else begin
                    cd_d[sel] = cd_eff;
                end
                state_d = (state_q == StSvcA) ? StSvcB : StDone;
            end
            StDone: begin
                first_d = ~first_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // State register; reset aborts any sequence without committing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            first_q    <= 1'b0;
            vga_prev_q <= 1'b1;
            cmd_q      <= '0;
            x_q        <= {GRID_MAX - 6'd2, 6'd2};
            y_q        <= {GRID_MAX - 6'd2, 6'd2};
            dir_q      <= {2'd2, 2'd0};
            cnt_q      <= '0;
            cd_q       <= '0;
            fire_vld_q <= 1'b0;
            fire_id_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            vga_prev_q <= vga_prev_d;
            cmd_q      <= cmd_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            cd_q       <= cd_d;
            fire_vld_q <= fire_vld_d;
            fire_id_q  <= fire_id_d;
            busy_q     <= busy_d;
        end
    end

    assign o_p0_x     = x_q[0];
    assign o_p0_y     = y_q[0];
    assign o_p0_dir   = dir_q[0];
    assign o_p1_x     = x_q[1];
    assign o_p1_y     = y_q[1];
    assign o_p1_dir   = dir_q[1];
    assign o_fire_vld = fire_vld_q;
    assign o_fire_id  = fire_id_q;
    assign o_busy     = busy_q;

endmodule

// File: doc/tank_scheduler.md
Name: tank_scheduler

Overview:
- Per-frame motion/fire scheduler for the two player tanks; owns tank position/direction state consumed by VGA and shoots bullets via a fire strobe.
- Samples debounced joystick commands, services both players once per frame during VGA non-busy time (vertical blank), round-robin order alternating each frame.
- Resolves border and tank-tank collisions before committing moves, so VGA never sees a mid-frame position change.

Parameters:
- GRID_MAX, 6'd39, largest legal x/y cell index (grid 0..GRID_MAX).
- MOVE_DIV, 4, frames between permitted moves per player (1..15).
- FIRE_CD, 30, frames of fire cooldown after a shot (1..63).

Ports:
- clk  in  1  system clock (25 MHz VGA domain).
- rst_n  in  1  asynchronous active-low reset.
- i_run  in  1  1 = play state; 0 = frozen (no moves, no fire, counters hold).
- i_vga_buzy  in  1  VGA busy; high while drawing active area.
- i_p0_cmd  in  5  player 0 {fire,right,left,down,up}, active-high, debounced.
- i_p1_cmd  in  5  player 1, same encoding.
- o_p0_x, o_p0_y  out  6 each  player 0 cell.
- o_p0_dir  out  2  player 0 heading: 00 up, 01 right, 10 down, 11 left.
- o_p1_x, o_p1_y, o_p1_dir  out  6/6/2  player 1, same.
- o_fire_vld  out  1  one-cycle shot strobe.
- o_fire_id  out  1  shooter of current strobe (0/1).
- o_busy  out  1  high while a service sequence is in progress.

Behaviour:
- Reset: P0 = (2,2) dir 00; P1 = (GRID_MAX-2, GRID_MAX-2) dir 10; o_fire_vld=0, o_fire_id=0, o_busy=0; move counters=0, cooldowns=0; first-served=P0; FSM=IDLE.
- Frame tick: 1-cycle pulse on i_vga_buzy falling edge (registered previous value, reset value 1). Ticks while i_run=0 are ignored.
- FSM: IDLE -(tick & i_run)-> LATCH -> SVC_A -> SVC_B -> DONE -> IDLE. LATCH registers both cmd buses; SVC_A serves first-served player, SVC_B the other; DONE toggles first-served. o_busy=1 in LATCH..DONE. Fixed 4-cycle sequence; completes even if i_vga_buzy rises meanwhile.
- Service of player k (one cycle, outputs update next edge):
  - Direction: highest-priority asserted bit up>down>left>right sets dir, even if move blocked; none -> dir unchanged.
  - Move counter: increments per serviced frame, saturating at MOVE_DIV-1. Move allowed if counter==MOVE_DIV-1 and a direction bit is set; on an attempted move counter clears to 0 (blocked or not).
  - Target = pos ±1 on heading axis. Blocked if target <0 or >GRID_MAX (6-bit arithmetic, underflow detected from pos==0), or target equals other tank's current committed position (SVC_B sees SVC_A's update).
  - Fire: if fire bit and cooldown==0 -> o_fire_vld=1, o_fire_id=k for exactly one cycle, cooldown=FIRE_CD. Cooldown decrements once per serviced frame, floor 0. Both fire same frame -> two strobes on consecutive cycles, first-served first.
- i_run falling mid-sequence: current sequence completes; no new sequence starts.
- Async reset mid-sequence: all state returns to reset values immediately; no partial commit.

Optional Feature:
- Macro TANK_SCHED_WRAP_EN. Defined: border moves wrap (0 -> GRID_MAX on decrement, GRID_MAX -> 0 on increment); tank-tank blocking still applies to wrapped target. Undefined: border moves blocked as above.

Test Plan:
- Reset, i_run=1, P0 cmd=up held, MOVE_DIV=4 -> P0 y steps 2->1->0 on frames 4 and 8, stays 0 after (dir 00), o_busy 4 cycles per frame.
- P0 at (5,5), P1 at (6,5), P0 right, P1 left, both counters ready -> first-served moves only if cell free; with P0 first: P0 blocked (6,5 occupied), P1 blocked (5,5); dirs become 01/11; positions unchanged.
- Both fire same frame, cooldowns 0 -> o_fire_vld pulses two consecutive cycles, ids in first-served order; repeat fire next 29 frames -> no strobe; frame 31 -> strobe.
- i_run=0 with cmds held for 10 frames -> no position/dir/fire change, o_busy stays 0.
- Assert rst_n low during SVC_A -> outputs at reset values same cycle; no fire strobe.
- With TANK_SCHED_WRAP_EN, P0 at x=0 moving left -> x=GRID_MAX (39); without macro -> x stays 0, dir 11.
